muldiv_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit beside the register file.
//  It consumes read_data1/read_data2 as rs1_data/rs2_data and produces the

---
 rtl/muldiv_unit.sv | 188 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per clock, holding the single-cycle core through stall while busy.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            stall,
    output logic [1:0]      dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    // Handshake: start is a level held by the decoder until done; the unit
    // accepts whenever it sees start in IDLE, and done marks the single cycle
    // in which result/rd_out are valid and the core may retire the instruction.

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_q, neg_d;
    logic              neg_rem_q, neg_rem_d;

    logic              sign_a, sign_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   special_res;

    logic [XLEN:0]     rem_sh;
    logic              rem_ge;
    logic [XLEN-1:0]   rem_sub;
    logic [2*XLEN-1:0] acc_nx, mcand_nx;
    logic [XLEN-1:0]   mplier_nx;

    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, final_res;

    // Operand conditioning at accept: signed operands become magnitudes.
    always_comb begin
        sign_a   = (funct3 inside {3'd1, 3'd2, 3'd4, 3'd6}) & rs1_data[XLEN-1];
        sign_b   = (funct3 inside {3'd1, 3'd4, 3'd6}) & rs2_data[XLEN-1];
        mag_a    = sign_a ? (~rs1_data + 1'b1) : rs1_data;
        mag_b    = sign_b ? (~rs2_data + 1'b1) : rs2_data;
        div_zero = funct3[2] & (rs2_data == '0);
        div_ovf  = funct3[2] & ~funct3[0] & (rs1_data == MIN_NEG) & (rs2_data == '1);
        special  = div_zero | div_ovf;
        if (div_zero) begin
            special_res = funct3[1] ? rs1_data : '1;
        end else begin
            special_res = funct3[1] ? '0 : rs1_data;
        end
    end

    // One iteration; for divide, mplier holds dividend bits shifting out and
    // quotient bits shifting in, acc low half holds the partial remainder.
    always_comb begin
        rem_sh  = {acc_q[XLEN-1:0], mplier_q[XLEN-1]};
        rem_ge  = rem_sh >= {1'b0, mcand_q[XLEN-1:0]};
        rem_sub = rem_sh[XLEN-1:0] - mcand_q[XLEN-1:0];
        if (op_q[2]) begin
            acc_nx    = {{XLEN{1'b0}}, (rem_ge ? rem_sub : rem_sh[XLEN-1:0])};
            mplier_nx = {mplier_q[XLEN-2:0], rem_ge};
            mcand_nx  = mcand_q;
        end else begin
            acc_nx    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
            mplier_nx = mplier_q >> 1;
            mcand_nx  = mcand_q << 1;
        end
    end

    // Sign fix-up and result select, evaluated on the final iteration.
    always_comb begin
        prod_s = neg_q ? (~acc_nx + 1'b1) : acc_nx;
        quo_s  = neg_q ? (~mplier_nx + 1'b1) : mplier_nx;
        rem_s  = neg_rem_q ? (~acc_nx[XLEN-1:0] + 1'b1) : acc_nx[XLEN-1:0];
        case (op_q)
            3'd0:                final_res = prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    final_res = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:          final_res = quo_s;
            default:             final_res = rem_s;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        rd_d      = rd_q;
        result_d  = result_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d      = funct3;
                    rd_d      = rd_in;
                    cnt_d     = '0;
                    neg_d     = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    acc_d     = '0;
                    if (special) begin
                        result_d = special_res;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                        if (funct3[2]) begin
                            mplier_d = mag_a;
                            mcand_d  = {{XLEN{1'b0}}, mag_b};
                        end else begin
                            mplier_d = mag_b;
                            mcand_d  = {{XLEN{1'b0}}, mag_a};
                        end
                    end
                end
            end
            ST_CALC: begin
                acc_d    = acc_nx;
                mplier_d = mplier_nx;
                mcand_d  = mcand_nx;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    result_d = final_res;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            result_q  <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            result_q  <= result_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign busy      = (state_q == ST_CALC) | (state_q == ST_DONE);
    assign done      = (state_q == ST_DONE);
    assign stall     = start & ~done;
    assign result    = result_q;
    assign rd_out    = rd_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M vectors, special cases, random ops
// against an arithmetic model, reset mid-operation and back-to-back ops.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        stall;
    logic [1:0]  dbg_state;

    int total;
    int bad;

    logic [31:0] exp_q[$];
    logic [4:0]  exp_rd_q[$];

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out),
        .stall(stall), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic using 64-bit signed products and native division.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        logic signed [31:0] x, y;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        x  = a;
        y  = b;
        p  = '0;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return x / y;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return x % y;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 0;
        return 32;
    endfunction

    // Driver: one op from IDLE. done_edge counts edges after the accept edge
    // until done is seen; stall_cyc counts stall-high cycles after accept.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                         output int done_edge, output int stall_cyc, output logic after_ok);
        @(negedge clk);
        start = 1'b1; funct3 = f; rs1_data = a; rs2_data = b; rd_in = rd;
        @(posedge clk);
        done_edge = -1; stall_cyc = 0; res = 'x; rdo = 'x;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 5) begin
                funct3 = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom; rd_in = 5'($urandom);
            end
            if (done) begin
                done_edge = k; res = result; rdo = rd_out;
                break;
            end
            if (stall) stall_cyc++;
        end
        start = 1'b0;
        @(negedge clk);
        after_ok = (done === 1'b0) && (busy === 1'b0) && (result === res) && (rd_out === rdo);
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0; rd_in = '0;
        #2;
        total++;
        if ({busy, done, stall, result, rd_out, dbg_state} !== '0) begin
            bad++;
            $display("FAIL reset outputs: busy=%b done=%b stall=%b result=%h rd_out=%0d state=%0d, want all 0",
                     busy, done, stall, result, rd_out, dbg_state);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, done, stall} !== 3'b000) begin
            bad++;
            $display("FAIL idle no start: busy=%b done=%b stall=%b, want 000", busy, done, stall);
        end
    endtask

    task automatic test_mul;
        logic [2:0]  fv[4] = '{3'd0, 3'd3, 3'd1, 3'd2};
        logic [31:0] av[4] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bv[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ev[4] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF};
        logic [31:0] res, e; logic [4:0] rdo, erd; int de, sc; logic aok;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(ev[i]); exp_rd_q.push_back(5'(i + 1));
            do_op(fv[i], av[i], bv[i], 5'(i + 1), res, rdo, de, sc, aok);
            e = exp_q.pop_front(); erd = exp_rd_q.pop_front();
            total += 4;
            if (res !== e) begin bad++; $display("FAIL mul[%0d] result: got %h want %h", i, res, e); end
            if (rdo !== erd) begin bad++; $display("FAIL mul[%0d] rd_out: got %0d want %0d", i, rdo, erd); end
            if (de !== 32 || sc !== 32) begin
                bad++; $display("FAIL mul[%0d] timing: done_edge %0d stall %0d want 32 32", i, de, sc);
            end
            if (!aok) begin bad++; $display("FAIL mul[%0d] pulse/hold: done/busy not low or outputs moved", i); end
        end
    endtask

    task automatic test_div;
        logic [2:0]  fv[4] = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] av[4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] bv[4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] ev[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        logic [31:0] res, e; logic [4:0] rdo, erd; int de, sc; logic aok;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(ev[i]); exp_rd_q.push_back(5'(i + 10));
            do_op(fv[i], av[i], bv[i], 5'(i + 10), res, rdo, de, sc, aok);
            e = exp_q.pop_front(); erd = exp_rd_q.pop_front();
            total += 3;
            if (res !== e) begin bad++; $display("FAIL div[%0d] result: got %h want %h", i, res, e); end
            if (rdo !== erd) begin bad++; $display("FAIL div[%0d] rd_out: got %0d want %0d", i, rdo, erd); end
            if (de !== 32 || !aok) begin
                bad++; $display("FAIL div[%0d] timing: done_edge %0d want 32, after_ok %b", i, de, aok);
            end
        end
    endtask

    task automatic test_special;
        logic [2:0]  fv[4] = '{3'd5, 3'd6, 3'd4, 3'd6};
        logic [31:0] av[4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bv[4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ev[4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        logic [31:0] res, e; logic [4:0] rdo, erd; int de, sc; logic aok;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(ev[i]); exp_rd_q.push_back(5'(i + 20));
            do_op(fv[i], av[i], bv[i], 5'(i + 20), res, rdo, de, sc, aok);
            e = exp_q.pop_front(); erd = exp_rd_q.pop_front();
            total += 3;
            if (res !== e) begin bad++; $display("FAIL special[%0d] result: got %h want %h", i, res, e); end
            if (rdo !== erd) begin bad++; $display("FAIL special[%0d] rd_out: got %0d want %0d", i, rdo, erd); end
            if (de !== 0 || sc !== 0 || !aok) begin
                bad++; $display("FAIL special[%0d] timing: done_edge %0d stall %0d want 0 0, after_ok %b", i, de, sc, aok);
            end
        end
    endtask

    task automatic test_random;
        logic [2:0] f; logic [31:0] a, b, res, e; logic [4:0] rd, rdo, erd;
        int de, sc, el; logic aok;
        for (int i = 0; i < 16; i++) begin
            f  = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 28);
            rd = 5'($urandom_range(1, 31));
            exp_q.push_back(model(f, a, b)); exp_rd_q.push_back(rd);
            el = model_lat(f, a, b);
            do_op(f, a, b, rd, res, rdo, de, sc, aok);
            e = exp_q.pop_front(); erd = exp_rd_q.pop_front();
            total += 2;
            if (res !== e || rdo !== erd) begin
                bad++; $display("FAIL rand[%0d] f=%0d a=%h b=%h: got %h rd %0d want %h rd %0d", i, f, a, b, res, rdo, e, erd);
            end
            if (de !== el || !aok) begin
                bad++; $display("FAIL rand[%0d] timing: done_edge %0d want %0d, after_ok %b", i, de, el, aok);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] e; logic [4:0] erd; int de;
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; rs1_data = 32'd1234; rs2_data = 32'd5678; rd_in = 5'd9;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if ({done, busy, result, rd_out} !== '0) begin
            bad++; $display("FAIL reset mid-calc: done=%b busy=%b result=%h rd_out=%0d, want all 0", done, busy, result, rd_out);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || dbg_state !== 2'd0) begin
            bad++; $display("FAIL reset hold: done=%b state=%0d, want 0 0", done, dbg_state);
        end
        exp_q.push_back(model(3'd0, 32'd1234, 32'd5678)); exp_rd_q.push_back(5'd9);
        rst = 1'b1;
        @(posedge clk);
        de = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) begin de = k; break; end
        end
        e = exp_q.pop_front(); erd = exp_rd_q.pop_front();
        total++;
        if (de !== 32 || result !== e || rd_out !== erd) begin
            bad++; $display("FAIL reset re-accept: done_edge %0d result %h rd %0d want 32 %h %0d", de, result, rd_out, e, erd);
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [31:0] e; logic [4:0] erd;
        int n_done, low_cnt, low_bad;
        n_done = 0; low_cnt = 0; low_bad = 0;
        exp_q.push_back(model(3'd0, 32'd123456, 32'd789)); exp_rd_q.push_back(5'd5);
        exp_q.push_back(model(3'd5, 32'd1000003, 32'd97)); exp_rd_q.push_back(5'd6);
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; rs1_data = 32'd123456; rs2_data = 32'd789; rd_in = 5'd5;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (!stall) begin
                low_cnt++;
                if (!done) low_bad++;
            end
            if (done) begin
                n_done++;
                e = exp_q.pop_front(); erd = exp_rd_q.pop_front();
                total++;
                if (result !== e || rd_out !== erd) begin
                    bad++; $display("FAIL b2b op%0d: got %h rd %0d want %h rd %0d", n_done, result, rd_out, e, erd);
                end
                if (n_done == 1) begin
                    funct3 = 3'd5; rs1_data = 32'd1000003; rs2_data = 32'd97; rd_in = 5'd6;
                end else begin
                    start = 1'b0;
                    break;
                end
            end
        end
        total++;
        if (n_done !== 2 || low_cnt !== 2 || low_bad !== 0) begin
            bad++; $display("FAIL b2b shape: done pulses %0d stall-low %0d stray-low %0d, want 2 2 0", n_done, low_cnt, low_bad);
        end
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
